// File: rtl/h14tx_pkg.sv
// Shared types and constants for the HDMI 1.4 data-island packet path.
package h14tx_pkg;

    localparam int PacketSlotClocks = 32;
    localparam int HdrBits          = 24;
    localparam int SubBits          = 224;
    localparam int SlotCntW         = $clog2(PacketSlotClocks);

    typedef logic [HdrBits-1:0] packet_hdr_t;
    typedef logic [SubBits-1:0] packet_sub_t;

    localparam packet_hdr_t NullPacketHdr = 24'h000000;
    localparam packet_sub_t NullPacketSub = '0;

    localparam logic [SlotCntW-1:0] PrefetchCnt = SlotCntW'(PacketSlotClocks - 3);
    localparam logic [SlotCntW-1:0] LastCnt     = SlotCntW'(PacketSlotClocks - 1);
    localparam logic [4:0]          SlotIdxMax  = 5'd31;

    typedef enum logic [2:0] {
        Control,
        VideoPreamble,
        VideoGuard,
        VideoActive,
        DataIslandPreamble,
        DataIslandGuard,
        DataIslandActive
    } period_t;

    typedef enum logic [1:0] {
        SchIdle,
        SchFetch,
        SchArmed,
        SchSend
    } sched_state_t;

endpackage

// File: rtl/h14tx_packet_scheduler_if.sv
// Requester-side bus of the packet scheduler: req/payload in, one-hot grant out.
interface h14tx_packet_scheduler_if
    import h14tx_pkg::*;
#(
    parameter int NumSources = 4
);

    logic [NumSources-1:0]         req;
    logic [NumSources*HdrBits-1:0] hdr_i;
    logic [NumSources*SubBits-1:0] sub_i;
    logic [NumSources-1:0]         grant;

    modport master (
        output req,
        output hdr_i,
        output sub_i,
        input  grant
    );

    modport slave (
        input  req,
        input  hdr_i,
        input  sub_i,
        output grant
    );

endinterface

// File: rtl/h14tx_packet_arbiter.sv
// Combinational req -> one-hot winner. Fixed priority (index 0 first) by default;
// H14TX_PKT_RR_EN selects round-robin starting at i_ptr.
module h14tx_packet_arbiter #(
    parameter int NumSources = 4
) (
    input  logic [NumSources-1:0]         i_req,
`ifdef H14TX_PKT_RR_EN
    input  logic [$clog2(NumSources)-1:0] i_ptr,
    output logic [$clog2(NumSources)-1:0] o_idx,
`endif
    output logic [NumSources-1:0]         o_grant
);

`ifdef H14TX_PKT_RR_EN
    logic w_found;

    // Scan distances 0..N-1 from the pointer; first requester found wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NumSources; k++) begin
            for (int i = 0; i < NumSources; i++) begin
                if (!w_found && i_req[i] &&
                    ((int'(i_ptr) + k) % NumSources == i)) begin
                    w_found    = 1'b1;
                    o_grant[i] = 1'b1;
                    o_idx      = $clog2(NumSources)'(i);
                end
            end
        end
    end
`else
    always_comb begin
        o_grant = '0;
        for (int i = NumSources - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/h14tx_packet_scheduler.sv
// Data-island packet scheduler: one packet per 32-clk slot, null fill when idle.
// Optional round-robin arbitration via H14TX_PKT_RR_EN.
module h14tx_packet_scheduler
    import h14tx_pkg::*;
#(
    parameter int NumSources = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  period_t                 i_timings,
    h14tx_packet_scheduler_if.slave bus,
    output packet_hdr_t             o_pkt_hdr,
    output packet_sub_t             o_pkt_sub,
    output logic                    o_pkt_start,
    output logic                    o_pkt_null,
    output logic [4:0]              o_slot_idx
);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [SlotCntW-1:0]   r_slot_cnt;
    logic [4:0]            r_slot_idx;
    packet_hdr_t           r_shadow_hdr;
    packet_sub_t           r_shadow_sub;
    logic                  r_shadow_vld;
    packet_hdr_t           r_pkt_hdr;
    packet_sub_t           r_pkt_sub;
    logic                  r_pkt_start;
    logic                  r_pkt_null;
    logic                  w_active;
    logic                  w_arb_en;
    logic                  w_load;
    logic                  w_drop;
    logic [NumSources-1:0] w_win_oh;
    packet_hdr_t           w_win_hdr;
    packet_sub_t           w_win_sub;

    assign w_active = (i_timings == DataIslandActive);

`ifdef H14TX_PKT_RR_EN
    localparam int IdxW = $clog2(NumSources);

    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] w_win_idx;

    h14tx_packet_arbiter #(.NumSources(NumSources)) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_idx   (w_win_idx),
        .o_grant (w_win_oh)
    );

    // Pointer moves to one past the winner, only on a real grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_arb_en && |bus.req) begin
            r_ptr <= (w_win_idx == IdxW'(NumSources - 1)) ? '0 : w_win_idx + 1'b1;
        end
    end
`else
    h14tx_packet_arbiter #(.NumSources(NumSources)) u_arb (
        .i_req   (bus.req),
        .o_grant (w_win_oh)
    );
`endif

    assign bus.grant = w_arb_en ? w_win_oh : '0;

    always_comb begin
        w_win_hdr = NullPacketHdr;
        w_win_sub = NullPacketSub;
        for (int i = 0; i < NumSources; i++) begin
            if (w_win_oh[i]) begin
                w_win_hdr = bus.hdr_i[i*HdrBits +: HdrBits];
                w_win_sub = bus.sub_i[i*SubBits +: SubBits];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SchIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A real packet left in shadow by a cut-short island blocks the next FETCH.
    always_comb begin
        w_state_nxt = r_state;
        w_arb_en    = 1'b0;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        unique case (r_state)
            SchIdle: begin
                if (i_timings == DataIslandPreamble) w_state_nxt = SchFetch;
            end
            SchFetch: begin
                w_arb_en    = !r_shadow_vld;
                w_state_nxt = SchArmed;
            end
            SchArmed: begin
                if (w_active) begin
                    w_load      = 1'b1;
                    w_state_nxt = SchSend;
                end
            end
            SchSend: begin
                if (!w_active) begin
                    w_drop      = 1'b1;
                    w_state_nxt = SchIdle;
                end else begin
                    w_arb_en = (r_slot_cnt == PrefetchCnt);
                    w_load   = (r_slot_cnt == LastCnt);
                end
            end
            default: w_state_nxt = SchIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot_cnt   <= '0;
            r_slot_idx   <= '0;
            r_shadow_hdr <= NullPacketHdr;
            r_shadow_sub <= NullPacketSub;
            r_shadow_vld <= 1'b0;
            r_pkt_hdr    <= NullPacketHdr;
            r_pkt_sub    <= NullPacketSub;
            r_pkt_start  <= 1'b0;
            r_pkt_null   <= 1'b0;
        end else begin
            r_pkt_start <= w_load;
            if (w_arb_en) begin
                r_shadow_hdr <= w_win_hdr;
                r_shadow_sub <= w_win_sub;
                r_shadow_vld <= |bus.req;
            end
            if (w_load) begin
                r_pkt_hdr    <= r_shadow_hdr;
                r_pkt_sub    <= r_shadow_sub;
                r_pkt_null   <= !r_shadow_vld;
                r_shadow_hdr <= NullPacketHdr;
                r_shadow_sub <= NullPacketSub;
                r_shadow_vld <= 1'b0;
                r_slot_cnt   <= '0;
                if (r_state == SchArmed) begin
                    r_slot_idx <= '0;
                end else if (r_slot_idx != SlotIdxMax) begin
                    r_slot_idx <= r_slot_idx + 1'b1;
                end
            end else if (r_state == SchSend) begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end
            if (w_drop) begin
                r_pkt_hdr  <= NullPacketHdr;
                r_pkt_sub  <= NullPacketSub;
                r_pkt_null <= 1'b0;
                r_slot_idx <= '0;
                r_slot_cnt <= '0;
            end
        end
    end

    assign o_pkt_hdr   = r_pkt_hdr;
    assign o_pkt_sub   = r_pkt_sub;
    assign o_pkt_start = r_pkt_start;
    assign o_pkt_null  = r_pkt_null;
    assign o_slot_idx  = r_slot_idx;

endmodule
